// File: rtl/frame_sequencer_if.sv
// Bundle of the pixel stream, pipeline control and host record signals
// seen by the frame sequencer. The master side is the sequencer and the
// slave side is the surrounding source, pipeline and host.
interface frame_sequencer_if #(
  parameter int LOC_W = 32,
  parameter int LBL_W = 8,
  parameter int PIX_W = 24
) ();

  // frame control and pixel stream from the source
  logic             start;
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;

  // pipeline drive and object readout
  logic             en;
  logic [LOC_W-1:0] x;
  logic [LOC_W-1:0] y;
  logic [PIX_W-1:0] data;
  logic [LBL_W-1:0] num_labels;
  logic [LBL_W-1:0] obj_id;
  logic [LOC_W-1:0] obj_area;
  logic [LOC_W-1:0] obj_x;
  logic [LOC_W-1:0] obj_y;

  // record channel to the host
  logic             rec_valid;
  logic             rec_ready;
  logic [LBL_W-1:0] rec_id;
  logic [LOC_W-1:0] rec_area;
  logic [LOC_W-1:0] rec_x;
  logic [LOC_W-1:0] rec_y;

  // status
  logic             busy;
  logic             frame_done;

  modport master (
    input  start, pix_valid, pix_data,
    input  num_labels, obj_area, obj_x, obj_y,
    input  rec_ready,
    output pix_ready, en, x, y, data, obj_id,
    output rec_valid, rec_id, rec_area, rec_x, rec_y,
    output busy, frame_done
  );

  modport slave (
    output start, pix_valid, pix_data,
    output num_labels, obj_area, obj_x, obj_y,
    output rec_ready,
    input  pix_ready, en, x, y, data, obj_id,
    input  rec_valid, rec_id, rec_area, rec_x, rec_y,
    input  busy, frame_done
  );

endinterface

// File: rtl/frame_sequencer.sv
// Frame-level controller for the detection pipeline. Streams one frame of
// pixels into the pipeline, flushes its latency with zero pixels, then
// walks every label and hands each object's statistics to the host as a
// registered record.
module frame_sequencer #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int LOC_W        = 32,
  parameter int LBL_W        = 8,
  parameter int PIX_W        = 24,
  parameter int FLUSH_CYCLES = 1300,
  parameter int READ_LAT     = 2
) (
  input logic              clk,
  input logic              reset,
  frame_sequencer_if.master bus
);

  // one counter serves both the flush run and the readout wait
  localparam int CNT_MAX = (FLUSH_CYCLES > READ_LAT) ? FLUSH_CYCLES : READ_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [LOC_W-1:0] X_LAST     = LOC_W'(FRAME_WIDTH - 1);
  localparam logic [LOC_W-1:0] Y_LAST     = LOC_W'(FRAME_HEIGHT - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LOC_W-1:0] x_q, x_d;
  logic [LOC_W-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LBL_W-1:0] nl_q, nl_d;
  logic [LBL_W-1:0] obj_id_q, obj_id_d;
  logic [LBL_W-1:0] rec_id_q, rec_id_d;
  logic [LOC_W-1:0] rec_area_q, rec_area_d;
  logic [LOC_W-1:0] rec_x_q, rec_x_d;
  logic [LOC_W-1:0] rec_y_q, rec_y_d;

  logic             en;
  logic             pix_ready;
  logic [PIX_W-1:0] data;
  logic             rec_valid;
  logic             frame_done;

  // state register; reset aborts any frame or readout and drops the record
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      nl_q       <= '0;
      obj_id_q   <= '0;
      rec_id_q   <= '0;
      rec_area_q <= '0;
      rec_x_q    <= '0;
      rec_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      nl_q       <= nl_d;
      obj_id_q   <= obj_id_d;
      rec_id_q   <= rec_id_d;
      rec_area_q <= rec_area_d;
      rec_x_q    <= rec_x_d;
      rec_y_q    <= rec_y_d;
    end
  end

  // next-state and strobe decode for stream, flush and object readout
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    nl_d       = nl_q;
    obj_id_d   = obj_id_q;
    rec_id_d   = rec_id_q;
    rec_area_d = rec_area_q;
    rec_x_d    = rec_x_q;
    rec_y_d    = rec_y_q;
    en         = 1'b0;
    pix_ready  = 1'b0;
    data       = '0;
    rec_valid  = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        x_d = '0;
        y_d = '0;
        if (bus.start) begin
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        pix_ready = 1'b1;
        en        = bus.pix_valid;
        data      = bus.pix_data;
        if (bus.pix_valid) begin
          if (x_q == X_LAST) begin
            if (y_q == Y_LAST) begin
              // last pixel: coordinates stay parked on the final pixel
              cnt_d   = '0;
              state_d = S_FLUSH;
            end else begin
              x_d = '0;
              y_d = y_q + LOC_W'(1);
            end
          end else begin
            x_d = x_q + LOC_W'(1);
          end
        end
      end

      S_FLUSH: begin
        en = 1'b1;
        if (cnt_q == FLUSH_LAST) begin
          // label count is frozen here for the rest of the frame
          nl_d  = bus.num_labels;
          cnt_d = '0;
          if (bus.num_labels == '0) begin
            state_d = S_DONE;
          end else begin
            obj_id_d = LBL_W'(1);
            state_d  = S_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          rec_id_d   = obj_id_q;
          rec_area_d = bus.obj_area;
          rec_x_d    = bus.obj_x;
          rec_y_d    = bus.obj_y;
          cnt_d      = '0;
          state_d    = S_OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_OUT: begin
        rec_valid = 1'b1;
        if (bus.rec_ready) begin
          if (obj_id_q == nl_q) begin
            state_d = S_DONE;
          end else begin
            obj_id_d = obj_id_q + LBL_W'(1);
            cnt_d    = '0;
            state_d  = S_WAIT;
          end
        end
      end

      S_DONE: begin
        frame_done = 1'b1;
        obj_id_d   = '0;
        x_d        = '0;
        y_d        = '0;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.en         = en;
  assign bus.pix_ready  = pix_ready;
  assign bus.data       = data;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.obj_id     = obj_id_q;
  assign bus.rec_valid  = rec_valid;
  assign bus.rec_id     = rec_id_q;
  assign bus.rec_area   = rec_area_q;
  assign bus.rec_x      = rec_x_q;
  assign bus.rec_y      = rec_y_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer on a 4x2 frame with a 3-cycle flush
// and 2-cycle object read latency. The pipeline's object statistics are
// a simple function of obj_id so every record has a known value.
module tb_frame_sequencer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int FC    = 3;
  localparam int RL    = 2;
  localparam int LOC_W = 32;
  localparam int LBL_W = 8;
  localparam int PIX_W = 24;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  // free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  frame_sequencer_if #(.LOC_W(LOC_W), .LBL_W(LBL_W), .PIX_W(PIX_W)) bus ();

  frame_sequencer #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .LOC_W(LOC_W), .LBL_W(LBL_W),
    .PIX_W(PIX_W), .FLUSH_CYCLES(FC), .READ_LAT(RL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  // stand-in pipeline statistics: area=10*id+5, x=id+100, y=id+200
  always_comb begin
    bus.obj_area = LOC_W'(bus.obj_id) * 32'd10 + 32'd5;
    bus.obj_x    = LOC_W'(bus.obj_id) + 32'd100;
    bus.obj_y    = LOC_W'(bus.obj_id) + 32'd200;
  end

  typedef struct {
    logic        start;
    logic        pv;
    logic [23:0] pdata;
    logic [7:0]  nl;
    logic        rr;
    logic [4:0]  e_ctrl;   // {en, pix_ready, busy, frame_done, rec_valid}
    logic [31:0] e_x;
    logic [31:0] e_y;
    logic [23:0] e_data;
    logic [7:0]  e_obj;
    logic [7:0]  e_rid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int s, int pv, int pd, int nl, int rr,
                              int ctrl, int x, int y, int d, int obj, int rid);
    vec_t v;
    v.start  = 1'(s);
    v.pv     = 1'(pv);
    v.pdata  = 24'(pd);
    v.nl     = 8'(nl);
    v.rr     = 1'(rr);
    v.e_ctrl = 5'(ctrl);
    v.e_x    = 32'(x);
    v.e_y    = 32'(y);
    v.e_data = 24'(d);
    v.e_obj  = 8'(obj);
    v.e_rid  = 8'(rid);
    return v;
  endfunction

  function automatic logic [4:0] ctrlNow();
    return {bus.en, bus.pix_ready, bus.busy, bus.frame_done, bus.rec_valid};
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.start      = v.start;
    bus.pix_valid  = v.pv;
    bus.pix_data   = v.pdata;
    bus.num_labels = v.nl;
    bus.rec_ready  = v.rr;
  endtask

  task automatic checkRecord(input string tag, input logic [7:0] rid);
    checkVal({tag, " rec_id/area"}, 64'({bus.rec_id, bus.rec_area}),
             64'({rid, 32'(rid) * 32'd10 + 32'd5}));
    checkVal({tag, " rec_x/y"}, {bus.rec_x, bus.rec_y},
             {32'(rid) + 32'd100, 32'(rid) + 32'd200});
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("row%0d", idx);
    checkVal({tag, " ctrl"}, 64'(ctrlNow()), 64'(v.e_ctrl));
    checkVal({tag, " x/y"}, {bus.x, bus.y}, {v.e_x, v.e_y});
    checkVal({tag, " data"}, 64'(bus.data), 64'(v.e_data));
    checkVal({tag, " obj_id"}, 64'(bus.obj_id), 64'(v.e_obj));
    if (v.e_ctrl[0]) checkRecord(tag, v.e_rid);
  endtask

  // start a frame, push all W*H pixels back to back, then run the flush
  task automatic runStreamAndFlush(input logic [7:0] nl, input string tag);
    @(negedge clk);
    bus.start = 1'b1; bus.pix_valid = 1'b0; bus.num_labels = nl; bus.rec_ready = 1'b0;
    #1 checkVal({tag, " idle ctrl"}, 64'(ctrlNow()), 64'(5'b00000));
    for (int i = 0; i < W * H; i++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.pix_valid = 1'b1; bus.pix_data = 24'(i + 1);
      #1;
      checkVal($sformatf("%s pix%0d ctrl", tag, i), 64'(ctrlNow()), 64'(5'b11100));
      checkVal($sformatf("%s pix%0d x/y", tag, i), {bus.x, bus.y}, {32'(i % W), 32'(i / W)});
    end
    for (int i = 0; i < FC; i++) begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
      #1;
      checkVal($sformatf("%s flush%0d ctrl", tag, i), 64'(ctrlNow()), 64'(5'b10100));
      checkVal($sformatf("%s flush%0d data", tag, i), 64'(bus.data), 64'(0));
    end
  endtask

  // watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = '0;
    bus.num_labels = '0; bus.rec_ready = 1'b0;

    // main frame: 3 labels, one valid gap, start ignored mid-stream,
    // num_labels changed after the flush latch
    vecs.push_back(mk(1, 0, 'h00, 3, 1, 'b00000, 0, 0, 'h00, 0, 0));
    vecs.push_back(mk(0, 1, 'h11, 3, 1, 'b11100, 0, 0, 'h11, 0, 0));
    vecs.push_back(mk(0, 1, 'h22, 3, 1, 'b11100, 1, 0, 'h22, 0, 0));
    vecs.push_back(mk(0, 0, 'h33, 3, 1, 'b01100, 2, 0, 'h33, 0, 0));
    vecs.push_back(mk(0, 1, 'h44, 3, 1, 'b11100, 2, 0, 'h44, 0, 0));
    vecs.push_back(mk(1, 1, 'h55, 3, 1, 'b11100, 3, 0, 'h55, 0, 0));
    vecs.push_back(mk(0, 1, 'h66, 3, 1, 'b11100, 0, 1, 'h66, 0, 0));
    vecs.push_back(mk(0, 1, 'h77, 3, 1, 'b11100, 1, 1, 'h77, 0, 0));
    vecs.push_back(mk(0, 1, 'h88, 3, 1, 'b11100, 2, 1, 'h88, 0, 0));
    vecs.push_back(mk(0, 1, 'h99, 3, 1, 'b11100, 3, 1, 'h99, 0, 0));
    vecs.push_back(mk(0, 1, 'hAA, 3, 1, 'b10100, 3, 1, 'h00, 0, 0));
    vecs.push_back(mk(0, 1, 'hAA, 3, 1, 'b10100, 3, 1, 'h00, 0, 0));
    vecs.push_back(mk(0, 1, 'hAA, 3, 1, 'b10100, 3, 1, 'h00, 0, 0));
    vecs.push_back(mk(0, 0, 'h00, 7, 1, 'b00100, 3, 1, 'h00, 1, 0));
    vecs.push_back(mk(0, 0, 'h00, 7, 1, 'b00100, 3, 1, 'h00, 1, 0));
    vecs.push_back(mk(0, 0, 'h00, 7, 1, 'b00101, 3, 1, 'h00, 1, 1));
    vecs.push_back(mk(0, 0, 'h00, 7, 1, 'b00100, 3, 1, 'h00, 2, 0));
    vecs.push_back(mk(0, 0, 'h00, 7, 1, 'b00100, 3, 1, 'h00, 2, 0));
    vecs.push_back(mk(0, 0, 'h00, 7, 1, 'b00101, 3, 1, 'h00, 2, 2));
    vecs.push_back(mk(0, 0, 'h00, 7, 1, 'b00100, 3, 1, 'h00, 3, 0));
    vecs.push_back(mk(0, 0, 'h00, 7, 1, 'b00100, 3, 1, 'h00, 3, 0));
    vecs.push_back(mk(0, 0, 'h00, 7, 1, 'b00101, 3, 1, 'h00, 3, 3));
    vecs.push_back(mk(0, 0, 'h00, 7, 1, 'b00110, 3, 1, 'h00, 3, 0));
    vecs.push_back(mk(0, 0, 'h00, 7, 1, 'b00000, 0, 0, 'h00, 0, 0));

    // reset state
    #2;
    checkVal("reset ctrl", 64'(ctrlNow()), 64'(5'b00000));
    checkVal("reset x/y", {bus.x, bus.y}, 64'(0));
    checkVal("reset obj/rec_id", 64'({bus.obj_id, bus.rec_id}), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
    end

    // empty frame: frame_done right after the flush, no record
    runStreamAndFlush(8'd0, "empty");
    @(negedge clk); #1;
    checkVal("empty done ctrl", 64'(ctrlNow()), 64'(5'b00110));
    @(negedge clk); #1;
    checkVal("empty idle ctrl", 64'(ctrlNow()), 64'(5'b00000));

    // back-pressured record: rec_* and obj_id hold while rec_ready is low
    runStreamAndFlush(8'd2, "stall");
    for (int i = 0; i < RL; i++) begin
      @(negedge clk); #1;
      checkVal($sformatf("stall wait%0d ctrl", i), 64'(ctrlNow()), 64'(5'b00100));
      checkVal($sformatf("stall wait%0d obj", i), 64'(bus.obj_id), 64'(1));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus.rec_ready = 1'b0; #1;
      checkVal($sformatf("stall hold%0d ctrl", i), 64'(ctrlNow()), 64'(5'b00101));
      checkVal($sformatf("stall hold%0d obj", i), 64'(bus.obj_id), 64'(1));
      checkRecord($sformatf("stall hold%0d", i), 8'd1);
    end
    @(negedge clk); bus.rec_ready = 1'b1; #1;
    checkVal("stall take1 ctrl", 64'(ctrlNow()), 64'(5'b00101));
    checkRecord("stall take1", 8'd1);
    for (int i = 0; i < RL; i++) begin
      @(negedge clk); bus.rec_ready = 1'b0; #1;
      checkVal($sformatf("stall gap%0d ctrl", i), 64'(ctrlNow()), 64'(5'b00100));
      checkVal($sformatf("stall gap%0d obj", i), 64'(bus.obj_id), 64'(2));
    end
    @(negedge clk); bus.rec_ready = 1'b1; #1;
    checkVal("stall take2 ctrl", 64'(ctrlNow()), 64'(5'b00101));
    checkRecord("stall take2", 8'd2);
    @(negedge clk); bus.rec_ready = 1'b0; #1;
    checkVal("stall done ctrl", 64'(ctrlNow()), 64'(5'b00110));
    @(negedge clk); #1;
    checkVal("stall idle ctrl", 64'(ctrlNow()), 64'(5'b00000));
    checkVal("stall idle obj", 64'(bus.obj_id), 64'(0));

    // reset after 5 pixels aborts the frame; the next start begins at 0,0
    @(negedge clk);
    bus.start = 1'b1; bus.pix_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.pix_valid = 1'b1; bus.pix_data = 24'h5A0000 + 24'(i);
      #1 checkVal($sformatf("abort pix%0d x/y", i), {bus.x, bus.y}, {32'(i % W), 32'(i / W)});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkVal("abort ctrl", 64'(ctrlNow()), 64'(5'b00000));
    checkVal("abort x/y", {bus.x, bus.y}, 64'(0));
    checkVal("abort data/obj", 64'({bus.data, bus.obj_id}), 64'(0));
    checkVal("abort rec", 64'({bus.rec_id, bus.rec_area}), 64'(0));
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b1; bus.pix_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.pix_valid = 1'b1; bus.pix_data = 24'h123456;
    #1;
    checkVal("restart ctrl", 64'(ctrlNow()), 64'(5'b11100));
    checkVal("restart x/y", {bus.x, bus.y}, 64'(0));
    @(negedge clk); #1;
    checkVal("restart next x/y", {bus.x, bus.y}, {32'd1, 32'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
